// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, synchronises and
// debounces the rows, and turns each accepted press into one command strobe
// on key_input/user_value/key_valid for gamelogic_top.
//
// Optional feature: define KEYPAD_REPEAT_EN to auto-repeat the arrow keys
// (UP/DOWN/LEFT/RIGHT) while they are held. Without it, exactly one strobe
// is produced per press and no repeat logic is built.
//
// Interface: key_valid is a one-cycle strobe with no back-pressure. While it
// is high, key_input carries the command code and user_value the digit
// (0 for non-digit codes). user_value then holds until the next strobe, and
// key_input returns to 0.
module keypad_scanner #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_input,
    output logic [3:0] user_value,
    output logic       key_valid
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [3:0] CMD_DIGIT  = 4'd1;
    localparam logic [3:0] CMD_UP     = 4'd2;
    localparam logic [3:0] CMD_CLEAR  = 4'd6;
    localparam logic [3:0] CMD_SELECT = 4'd7;
    localparam logic [3:0] CMD_ENTER  = 4'd8;

    // Reject parameter values the timing scheme cannot support: the row
    // sample needs two synchroniser cycles after the column switches.
    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_RELEASE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       row_s1;
    logic [3:0]       row_s2;
    logic [1:0]       col_idx;
    logic [1:0]       row_idx;
    logic [3:0]       row_pat;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;

    logic [3:0]       low_rows;
    logic             one_low;
    logic [1:0]       low_idx;
    logic             scan_last;
    logic             cnt_last;
    logic             pat_match;
    logic             all_high;
    logic [3:0]       cmd_code;
    logic [3:0]       cmd_digit;

    assign low_rows  = ~row_s2;
    assign scan_last = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign cnt_last  = (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign pat_match = (row_s2 == row_pat);
    assign all_high  = (row_s2 == 4'hF);

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_active;
    logic             rep_first;
    logic             rep_fire;
    logic             is_dir;

    // Arrow keys all live in column 3.
    assign is_dir   = (col_idx == 2'd3);
    assign rep_fire = rep_active && pat_match &&
                      (rep_cnt == (rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1)));
`endif

    // Classify the synchronised row sample: exactly one low row, and which.
    always_comb begin
        one_low = (low_rows != 4'd0) && ((low_rows & (low_rows - 4'd1)) == 4'd0);
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (low_rows[i]) low_idx = 2'(i);
        end
    end

    // Translate the latched (row, column) into a command code and digit.
    always_comb begin
        cmd_code  = 4'd0;
        cmd_digit = 4'd0;
        if (col_idx != 2'd3 && row_idx != 2'd3) begin
            cmd_code  = CMD_DIGIT;
            cmd_digit = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
        end else if (col_idx == 2'd3) begin
            cmd_code = CMD_UP + {2'b00, row_idx};
        end else begin
            case (col_idx)
                2'd0:    cmd_code = CMD_SELECT;
                2'd1:    cmd_code = CMD_CLEAR;
                default: cmd_code = CMD_ENTER;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_SCAN;
        else       state <= next_state;
    end

    // FSM next-state decision.
    always_comb begin
        next_state = state;
        case (state)
            ST_SCAN: begin
                if (scan_last && one_low) next_state = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!pat_match)    next_state = ST_SCAN;
                else if (cnt_last) next_state = ST_EMIT;
            end
            ST_EMIT: begin
                next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (all_high && cnt_last) next_state = ST_SCAN;
`ifdef KEYPAD_REPEAT_EN
                else if (rep_fire)        next_state = ST_EMIT;
`endif
            end
            default: next_state = ST_SCAN;
        endcase
    end

    // Row synchroniser, column stepping, press latch and debounce counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_s1  <= 4'hF;
            row_s2  <= 4'hF;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            row_pat <= 4'hF;
            div_cnt <= '0;
            deb_cnt <= '0;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
            case (state)
                ST_SCAN: begin
                    if (scan_last) begin
                        div_cnt <= '0;
                        if (one_low) begin
                            row_idx <= low_idx;
                            row_pat <= row_s2;
                            deb_cnt <= '0;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!pat_match) begin
                        deb_cnt <= '0;
                        col_idx <= col_idx + 2'd1;
                    end else if (cnt_last) begin
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                ST_EMIT: begin
                    deb_cnt <= '0;
                end
                ST_RELEASE: begin
                    if (!all_high) begin
                        deb_cnt <= '0;
                    end else if (cnt_last) begin
                        deb_cnt <= '0;
                        col_idx <= col_idx + 2'd1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // user_value is loaded as the strobe starts so it is valid alongside it.
    always_ff @(posedge clock) begin
        if (reset)                     user_value <= 4'd0;
        else if (next_state == ST_EMIT) user_value <= cmd_digit;
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat timing: counts held cycles since the last strobe while the
    // original arrow-key pattern stays present; any other sample cancels it.
    always_ff @(posedge clock) begin
        if (reset) begin
            rep_cnt    <= '0;
            rep_active <= 1'b0;
            rep_first  <= 1'b0;
        end else begin
            case (state)
                ST_DEBOUNCE: begin
                    rep_first  <= 1'b1;
                    rep_active <= 1'b0;
                    rep_cnt    <= '0;
                end
                ST_EMIT: begin
                    rep_cnt    <= REP_W'(1);
                    rep_active <= is_dir;
                end
                ST_RELEASE: begin
                    if (!pat_match)      rep_active <= 1'b0;
                    else if (rep_active) rep_cnt    <= rep_cnt + 1'b1;
                    if (rep_fire)        rep_first  <= 1'b0;
                end
                default: begin
                    rep_active <= 1'b0;
                    rep_cnt    <= '0;
                end
            endcase
        end
    end
`endif

    // Column drive and strobe outputs follow the registered state directly.
    assign col_out   = ~(4'b0001 << col_idx);
    assign key_valid = (state == ST_EMIT);
    assign key_input = key_valid ? cmd_code : 4'd0;

endmodule
